// File: rtl/alu_seq.sv
// Microcoded sequencer for the shared ALU: eight-entry writable program store,
// four-entry register file, fetch/execute loop with writeback from the ALU result.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               prog_we_i,
  input  logic [2:0]         prog_addr_i,
  input  logic [9:0]         prog_data_i,
  input  logic               reg_we_i,
  input  logic [1:0]         reg_addr_i,
  input  logic [WIDTH-1:0]   reg_wdata_i,
  input  logic [1:0]         rd_addr_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               en_o,
  output logic [2:0]         ctl_o,
  output logic [2*WIDTH-1:0] AB_o,
  input  logic [2*WIDTH-1:0] BC_i
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_e;

  state_e             state_q;
  logic [2:0]         pc_q;
  logic [2:0]         pc_d;
  logic [9:0]         instr_q;
  logic [9:0]         prog_q [8];
  logic [WIDTH-1:0]   rf_q [4];
  logic               busy_q;
  logic               done_q;
  logic               en_q;
  logic [2:0]         ctl_q;
  logic [2*WIDTH-1:0] ab_q;
  logic [9:0]         fetchWord;
  logic               seqUnused;

  assign pc_d      = pc_q + 3'd1;
  assign fetchWord = prog_q[pc_q];

  // Upper ALU half and the op/source fields of the latched word are never consumed.
  assign seqUnused = ^{BC_i[2*WIDTH-1:WIDTH], instr_q[8:6], instr_q[3:0]};

  // ab_q doubles as the A/B operand latches; ALU-facing outputs are registered
  // so they are exactly zero outside EXEC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      ctl_q   <= '0;
      ab_q    <= '0;
      for (int i = 0; i < 8; i++) prog_q[i] <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (prog_we_i) prog_q[prog_addr_i] <= prog_data_i;
          if (reg_we_i) rf_q[reg_addr_i] <= reg_wdata_i;
          if (start_i) begin
            pc_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          instr_q <= fetchWord;
          ab_q    <= {rf_q[fetchWord[3:2]], rf_q[fetchWord[1:0]]};
          ctl_q   <= fetchWord[8:6];
          en_q    <= 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          rf_q[instr_q[5:4]] <= BC_i[WIDTH-1:0];
          en_q  <= 1'b0;
          ctl_q <= '0;
          ab_q  <= '0;
          if (instr_q[9] || pc_q == 3'd7) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            pc_q    <= pc_d;
            state_q <= FETCH;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign en_o      = en_q;
  assign ctl_o     = ctl_q;
  assign AB_o      = ab_q;
  assign rd_data_o = rf_q[rd_addr_i];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; the bench itself plays the combinational ALU
// and checks timing, results, ignored host activity and reset behaviour.
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic               prog_we_i;
  logic [2:0]         prog_addr_i;
  logic [9:0]         prog_data_i;
  logic               reg_we_i;
  logic [1:0]         reg_addr_i;
  logic [WIDTH-1:0]   reg_wdata_i;
  logic [1:0]         rd_addr_i;
  logic [WIDTH-1:0]   rd_data_o;
  logic               en_o;
  logic [2:0]         ctl_o;
  logic [2*WIDTH-1:0] AB_o;
  logic [2*WIDTH-1:0] BC_i;

  int testsRun = 0;
  int testsFailed = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o),
    .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
    .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .en_o(en_o), .ctl_o(ctl_o), .AB_o(AB_o), .BC_i(BC_i)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the shared combinational ALU.
  logic [WIDTH-1:0] aluA, aluB, aluRes;
  always_comb begin
    aluA = AB_o[2*WIDTH-1:WIDTH];
    aluB = AB_o[WIDTH-1:0];
    aluRes = '0;
    case (ctl_o)
      3'b000: aluRes = '0;
      3'b001: aluRes = '1;
      3'b010: aluRes = aluA;
      3'b011: aluRes = aluB;
      3'b100: aluRes = aluA + aluB;
      3'b101: aluRes = aluA - aluB;
      3'b110: aluRes = aluA & aluB;
      default: aluRes = aluA | aluB;
    endcase
    BC_i = {{WIDTH{1'b0}}, aluRes};
  end

  function automatic logic [9:0] mkInstr(input logic halt, input logic [2:0] op,
                                         input logic [1:0] dst, input logic [1:0] sa,
                                         input logic [1:0] sb);
    return {halt, op, dst, sa, sb};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic regWe, input logic [1:0] regAddr,
                               input logic [7:0] regData, input logic progWe,
                               input logic [2:0] progAddr, input logic [9:0] progData);
    reg_we_i    = regWe;
    reg_addr_i  = regAddr;
    reg_wdata_i = regData;
    prog_we_i   = progWe;
    prog_addr_i = progAddr;
    prog_data_i = progData;
    step();
    reg_we_i  = 1'b0;
    prog_we_i = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [7:0] data);
    rd_addr_i = addr;
    #1;
    data = rd_data_o;
  endtask

  task automatic runProgram(output int doneCycle, output int enCount);
    doneCycle = -1;
    enCount = 0;
    start_i = 1'b1;
    for (int c = 1; c <= 40 && doneCycle < 0; c++) begin
      step();
      start_i = 1'b0;
      if (en_o) enCount++;
      if (done_o) doneCycle = c;
    end
    if (doneCycle < 0) checkOutput("runTimeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic loadChain();
    applyStimulus(1'b1, 2'd0, 8'h0F, 1'b1, 3'd0, mkInstr(1'b0, 3'b100, 2'd2, 2'd0, 2'd1));
    applyStimulus(1'b1, 2'd1, 8'h30, 1'b1, 3'd1, mkInstr(1'b0, 3'b110, 2'd3, 2'd2, 2'd0));
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 3'd2, mkInstr(1'b1, 3'b111, 2'd0, 2'd3, 2'd1));
  endtask

  logic [7:0] rdVal;
  int doneCycle, enCount, doneCount;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0;
    prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
    reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0; rd_addr_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    step();

    // Reset while idle after loading non-zero registers
    applyStimulus(1'b1, 2'd0, 8'hA5, 1'b1, 3'd0, mkInstr(1'b1, 3'b100, 2'd1, 2'd0, 2'd0));
    applyStimulus(1'b1, 2'd3, 8'h5A, 1'b0, 3'd0, 10'd0);
    rst_ni = 1'b0;
    #1;
    checkOutput("rstBusy", {31'd0, busy_o}, 32'd0);
    checkOutput("rstDone", {31'd0, done_o}, 32'd0);
    checkOutput("rstEn", {31'd0, en_o}, 32'd0);
    checkOutput("rstCtl", {29'd0, ctl_o}, 32'd0);
    checkOutput("rstAB", {16'd0, AB_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      readReg(i[1:0], rdVal);
      checkOutput($sformatf("rstRf%0d", i), {24'd0, rdVal}, 32'd0);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    step();

    // Single ADD with cycle-level checks
    applyStimulus(1'b1, 2'd0, 8'h25, 1'b0, 3'd0, 10'd0);
    applyStimulus(1'b1, 2'd1, 8'h1A, 1'b1, 3'd0, mkInstr(1'b1, 3'b100, 2'd2, 2'd0, 2'd1));
    start_i = 1'b1;
    checkOutput("addC0Busy", {31'd0, busy_o}, 32'd0);
    step();
    start_i = 1'b0;
    checkOutput("addC1Busy", {31'd0, busy_o}, 32'd1);
    checkOutput("addC1En", {31'd0, en_o}, 32'd0);
    step();
    checkOutput("addC2En", {31'd0, en_o}, 32'd1);
    checkOutput("addC2Ctl", {29'd0, ctl_o}, 32'd4);
    checkOutput("addC2AB", {16'd0, AB_o}, 32'h251A);
    step();
    checkOutput("addC3Done", {31'd0, done_o}, 32'd1);
    checkOutput("addC3Busy", {31'd0, busy_o}, 32'd0);
    checkOutput("addC3En", {31'd0, en_o}, 32'd0);
    checkOutput("addC3AB", {16'd0, AB_o}, 32'h0);
    readReg(2'd2, rdVal);
    checkOutput("addR2", {24'd0, rdVal}, 32'h3F);
    step();
    checkOutput("addC4Done", {31'd0, done_o}, 32'd0);

    // Wrap-around on ADD and SUB
    applyStimulus(1'b1, 2'd0, 8'hF0, 1'b1, 3'd0, mkInstr(1'b1, 3'b100, 2'd3, 2'd0, 2'd1));
    applyStimulus(1'b1, 2'd1, 8'h20, 1'b0, 3'd0, 10'd0);
    runProgram(doneCycle, enCount);
    readReg(2'd3, rdVal);
    checkOutput("wrapAdd", {24'd0, rdVal}, 32'h10);
    applyStimulus(1'b1, 2'd0, 8'h05, 1'b1, 3'd0, mkInstr(1'b1, 3'b101, 2'd3, 2'd0, 2'd1));
    applyStimulus(1'b1, 2'd1, 8'h07, 1'b0, 3'd0, 10'd0);
    runProgram(doneCycle, enCount);
    readReg(2'd3, rdVal);
    checkOutput("wrapSub", {24'd0, rdVal}, 32'hFE);
    checkOutput("wrapSubDone", doneCycle, 32'd3);

    // Dependency chain
    loadChain();
    runProgram(doneCycle, enCount);
    checkOutput("chainDone", doneCycle, 32'd7);
    checkOutput("chainEn", enCount, 32'd3);
    readReg(2'd2, rdVal);
    checkOutput("chainR2", {24'd0, rdVal}, 32'h3F);
    readReg(2'd3, rdVal);
    checkOutput("chainR3", {24'd0, rdVal}, 32'h0F);
    readReg(2'd0, rdVal);
    checkOutput("chainR0", {24'd0, rdVal}, 32'h3F);

    // Eight instructions without halt: r1 += r0, with ignored start and host writes
    for (int i = 0; i < 8; i++)
      applyStimulus(i < 3, i[1:0], (i == 0) ? 8'h01 : ((i == 2) ? 8'h55 : 8'h00),
                    1'b1, i[2:0], mkInstr(1'b0, 3'b100, 2'd1, 2'd1, 2'd0));
    doneCycle = -1; enCount = 0; doneCount = 0;
    start_i = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      start_i = (c == 5);
      reg_we_i = (c == 9); reg_addr_i = 2'd2; reg_wdata_i = 8'hAA;
      prog_we_i = (c == 9); prog_addr_i = 3'd7;
      prog_data_i = mkInstr(1'b0, 3'b000, 2'd1, 2'd1, 2'd0);
      if (en_o) enCount++;
      if (done_o) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
    end
    reg_we_i = 1'b0; prog_we_i = 1'b0; start_i = 1'b0;
    checkOutput("fullDone", doneCycle, 32'd17);
    checkOutput("fullEnPulses", enCount, 32'd8);
    checkOutput("fullDoneCount", doneCount, 32'd1);
    checkOutput("fullIdleAfter", {31'd0, busy_o}, 32'd0);
    readReg(2'd1, rdVal);
    checkOutput("fullR1", {24'd0, rdVal}, 32'h08);
    readReg(2'd2, rdVal);
    checkOutput("fullR2Kept", {24'd0, rdVal}, 32'h55);

    // Reset in the middle of EXEC of the chain's second instruction
    step();
    loadChain();
    start_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      start_i = 1'b0;
    end
    checkOutput("midEnBefore", {31'd0, en_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("midBusy", {31'd0, busy_o}, 32'd0);
    checkOutput("midEn", {31'd0, en_o}, 32'd0);
    checkOutput("midDone", {31'd0, done_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      readReg(i[1:0], rdVal);
      checkOutput($sformatf("midRf%0d", i), {24'd0, rdVal}, 32'd0);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    loadChain();
    runProgram(doneCycle, enCount);
    checkOutput("rerunDone", doneCycle, 32'd7);
    readReg(2'd2, rdVal);
    checkOutput("rerunR2", {24'd0, rdVal}, 32'h3F);
    readReg(2'd3, rdVal);
    checkOutput("rerunR3", {24'd0, rdVal}, 32'h0F);
    readReg(2'd0, rdVal);
    checkOutput("rerunR0", {24'd0, rdVal}, 32'h3F);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Microcoded sequencer that drives the shared `alu` datapath from a small writable program store and a four-entry register file. A host preloads operands and up to eight instructions while the block is idle, then pulses `start_i`. The block fetches operands, presents them to the ALU on its `en_i`/`ctl_i`/`AB_i` inputs, and writes the result back. It sits directly in front of one `alu` instance, with `WIDTH` matched between the two.

## Interface
- `WIDTH`, 8: ALU and register data width.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_ni` input 1: asynchronous active-low reset; asserts immediately, releases synchronously to `clk_i`.
- `start_i` input 1: run request; sampled only in IDLE.
- `busy_o` output 1: high in FETCH and EXEC.
- `done_o` output 1: one-cycle pulse in DONE.
- `prog_we_i` input 1: program-store write strobe; honoured only in IDLE.
- `prog_addr_i` input 3: program-store write address.
- `prog_data_i` input 10: instruction word `{halt[9], op[8:6], dst[5:4], srcA[3:2], srcB[1:0]}`.
- `reg_we_i` input 1: register write strobe; honoured only in IDLE.
- `reg_addr_i` input 2: register write address.
- `reg_wdata_i` input WIDTH: register write data.
- `rd_addr_i` input 2: register read address.
- `rd_data_o` output WIDTH: combinational read of `rf[rd_addr_i]`.
- `en_o` output 1: drives ALU `en_i`.
- `ctl_o` output 3: drives ALU `ctl_i`.
- `AB_o` output 2*WIDTH: drives ALU `AB_i` as `{A, B}`.
- `BC_i` input 2*WIDTH: ALU `BC_o`; the result is `BC_i[WIDTH-1:0]`.

## Operation

**ALU op encoding**
- 000 = 0
- 001 = all ones
- 010 = A
- 011 = B
- 100 = A+B
- 101 = A−B
- 110 = A&B
- 111 = A|B
- All arithmetic is modulo 2^WIDTH. Carry and borrow are discarded.

**State machine: IDLE, FETCH, EXEC, DONE**
- IDLE: if `start_i`, set pc←0 and go to FETCH. Otherwise stay. Host writes are accepted here only; `prog_we_i` and `reg_we_i` may both be asserted in the same cycle.
- FETCH: latch `instr←prog[pc]`, `A←rf[srcA]`, `B←rf[srcB]`, then go to EXEC.
- EXEC: drive `en_o`=1, `ctl_o`=op and `AB_o`={A,B}. On the clock edge ending EXEC, `rf[dst]←BC_i[WIDTH-1:0]`.
  - If halt=1 or pc=7, go to DONE.
  - Otherwise pc←pc+1 and go to FETCH.
  - pc never wraps.
- DONE: `done_o`=1, then go to IDLE.

**Output and input rules**
- Outside EXEC, `en_o`, `ctl_o` and `AB_o` are 0.
- `start_i` outside IDLE is ignored and is not queued.
- Host writes outside IDLE are dropped.

**Hazards**
- Writeback completes before the next FETCH, so back-to-back dependent instructions read the updated value. No forwarding is needed.
- `rd_data_o` reflects a writeback from the cycle after the EXEC edge.

**Reset**
- Asynchronous `rst_ni`=0 in any state forces IDLE and clears pc, the latched instruction, the A and B latches, all `rf` entries and all `prog` entries.
- All outputs go to 0, including `rd_data_o`.
- A run interrupted mid-EXEC performs no writeback.

## Timing
- Cycle 0: `start_i` sampled high in IDLE.
- Instruction k is in FETCH at cycle 1+2k and in EXEC at cycle 2+2k.
- Its result is visible on `rd_data_o` from cycle 3+2k.
- For an N-instruction program, `done_o` is high at cycle 1+2N and `busy_o` is high over cycles 1..2N.
- The earliest next `start_i` is accepted at cycle 2+2N.
- A maximal 8-instruction run gives `done_o` at cycle 17.
- The ALU is treated as combinational: `BC_i` must settle within the EXEC cycle.

## Test plan
1. Reset: assert `rst_ni`=0 mid-idle. Required: every output 0, and `rd_data_o`=0 for all four addresses.
2. Single ADD (WIDTH=8):
   - Setup: r0=0x25, r1=0x1A, prog[0]={halt=1, op=100, dst=2, srcA=0, srcB=1}; start at cycle 0.
   - Required: at cycle 2, `en_o`=1, `ctl_o`=100, `AB_o`=0x251A.
   - Required: at cycle 3, `done_o`=1 and r2 reads 0x3F.
3. Wrap-around:
   - r0=0xF0, r1=0x20 with ADD into r3. Required: r3=0x10.
   - r0=0x05, r1=0x07 with SUB into r3. Required: r3=0xFE.
4. Dependency chain:
   - Setup: r0=0x0F, r1=0x30.
   - Program: `r2=r0+r1`; `r3=r2&r0`; `r0=r3|r1` with halt.
   - Required: r2=0x3F, r3=0x0F, r0=0x3F, `done_o` at cycle 7.
5. No halt bit in any of the 8 instructions.
   - Required: `done_o` at cycle 17 and exactly 8 `en_o` pulses.
   - Required: a `start_i` at cycle 5 and a `prog_we_i`/`reg_we_i` at cycle 9 have no effect, checked against prog and rf contents.
6. Reset during EXEC at cycle 4 of test 4.
   - Required: `busy_o`, `en_o` and `done_o` drop immediately, and all registers read 0.
   - Required: after release, a new start runs correctly.
